// File: rtl/wino_pkg.sv
// Shared types and constants for the Winograd F(2x2,3x3) element-wise multiply-accumulate stage.
package wino_pkg;

   localparam int TILE_DIM   = 4;
   localparam int TILE_ELEMS = TILE_DIM * TILE_DIM;

   localparam int WD_DEF   = 10;
   localparam int WG_DEF   = 10;
   localparam int WI_DEF   = 24;
   localparam int CH_W_DEF = 10;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DRAIN,
      OUT
   } state_t;

   // Flat element index of a tile position; row 0 occupies k = 0..3.
   function automatic int elem_idx(input int row, input int col);
      return row * TILE_DIM + col;
   endfunction

endpackage

// File: rtl/wino_mac_lane.sv
// One tile element: registered product, then load-or-add accumulator and result latch.
// Saturating accumulation and a sticky overflow flag are built when WINO_EWMM_SAT_EN is defined.
module wino_mac_lane #(
   parameter int WD = 10,
   parameter int WG = 10,
   parameter int WI = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld,
   input  logic          vld,
   input  logic          first,
   input  logic          last,
   input  logic [WD-1:0] d,
   input  logic [WG-1:0] g,
   output logic [WI-1:0] m
`ifdef WINO_EWMM_SAT_EN
   ,
   output logic          sat
`endif
);

   localparam int WP = WD + WG;

   logic signed [WP-1:0] prod_p1;
   logic signed [WI-1:0] acc_p2;
   logic signed [WI-1:0] p_ext;
   logic signed [WI-1:0] sum;

   assign p_ext = WI'(prod_p1);

`ifdef WINO_EWMM_SAT_EN
   logic signed [WI:0] wide;
   logic               ovf;

   function automatic logic signed [WI-1:0] sat_wi(input logic signed [WI:0] v);
      if (v[WI] != v[WI-1])
         return v[WI] ? {1'b1, {(WI-1){1'b0}}} : {1'b0, {(WI-1){1'b1}}};
      return v[WI-1:0];
   endfunction

   // The first product of a group can never overflow because WI >= WD+WG.
   assign wide = (WI+1)'(acc_p2) + (WI+1)'(p_ext);
   assign ovf  = !first && (wide[WI] != wide[WI-1]);
   assign sum  = first ? p_ext : sat_wi(wide);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sat <= 1'b0;
      else if (vld)
         sat <= (first ? 1'b0 : sat) | ovf;
   end
`else
   assign sum = first ? p_ext : acc_p2 + p_ext;
`endif

   // p1: product register; p2: accumulator and completed result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_p1 <= '0;
         acc_p2  <= '0;
         m       <= '0;
      end else begin
         if (ld)
            prod_p1 <= WP'($signed(d)) * WP'($signed(g));
         if (vld)
            acc_p2 <= sum;
         if (vld && last)
            m <= sum;
      end
   end

endmodule

// File: rtl/wino_ewmm_accum.sv
// Winograd element-wise multiply-accumulate over a channel group: 16 MAC lanes plus group FSM.
// Define WINO_EWMM_SAT_EN for saturating accumulation and the sat_flag output.
module wino_ewmm_accum
   import wino_pkg::*;
#(
   parameter int WD   = WD_DEF,
   parameter int WG   = WG_DEF,
   parameter int WI   = WI_DEF,
   parameter int CH_W = CH_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CH_W-1:0]        cfg_num_ch,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [TILE_ELEMS*WD-1:0] d_tile,
   input  logic [TILE_ELEMS*WG-1:0] g_tile,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [TILE_ELEMS*WI-1:0] M,
   output logic                   busy
`ifdef WINO_EWMM_SAT_EN
   ,
   output logic                   sat_flag
`endif
);

   state_t          state;
   logic [CH_W-1:0] n_q;
   logic [CH_W-1:0] cnt;
   logic [CH_W-1:0] n_first;
   logic            accept;
   logic            vld_p1;
   logic            first_p1;
   logic            last_p1;

   assign accept  = in_valid && in_ready;
   assign n_first = (cfg_num_ch == '0) ? CH_W'(1) : cfg_num_ch;
   assign busy    = (state != IDLE);

   // p0 -> p1: beat acceptance, group bookkeeping and flags that follow the product register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         n_q      <= '0;
         cnt      <= '0;
         in_ready <= 1'b0;
         m_valid  <= 1'b0;
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
      end else begin
         vld_p1   <= accept;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  n_q      <= n_first;
                  cnt      <= CH_W'(1);
                  first_p1 <= 1'b1;
                  if (n_first == CH_W'(1)) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                     last_p1  <= 1'b1;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            ACC: begin
               if (accept) begin
                  cnt <= cnt + CH_W'(1);
                  if (cnt == n_q - CH_W'(1)) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                     last_p1  <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               state   <= OUT;
               m_valid <= 1'b1;
            end
            OUT: begin
               if (m_ready) begin
                  state    <= IDLE;
                  m_valid  <= 1'b0;
                  in_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WINO_EWMM_SAT_EN
   logic [TILE_ELEMS-1:0] sat_lane;
   assign sat_flag = |sat_lane;
`endif

   for (genvar r = 0; r < TILE_DIM; r++) begin : g_row
      for (genvar c = 0; c < TILE_DIM; c++) begin : g_col
         localparam int K = elem_idx(r, c);
         wino_mac_lane #(
            .WD(WD),
            .WG(WG),
            .WI(WI)
         ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .ld    (accept),
            .vld   (vld_p1),
            .first (first_p1),
            .last  (last_p1),
            .d     (d_tile[K*WD +: WD]),
            .g     (g_tile[K*WG +: WG]),
            .m     (M[K*WI +: WI])
`ifdef WINO_EWMM_SAT_EN
            ,
            .sat   (sat_lane[K])
`endif
         );
      end
   end

endmodule

// File: tb/tb_wino_ewmm_accum.sv
// Scoreboard bench for wino_ewmm_accum: directed groups push expected M tiles, a monitor pops on handshake.
module tb_wino_ewmm_accum;

   localparam int WD   = 10;
   localparam int WG   = 10;
   localparam int WI   = 24;
   localparam int CH_W = 10;
   localparam int NE   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH_W-1:0]   cfg_num_ch;
   logic              in_valid;
   logic              in_ready;
   logic [NE*WD-1:0]  d_tile;
   logic [NE*WG-1:0]  g_tile;
   logic              m_valid;
   logic              m_ready;
   logic [NE*WI-1:0]  M;
   logic              busy;
`ifdef WINO_EWMM_SAT_EN
   logic              sat_flag;
`endif

   wino_ewmm_accum #(
      .WD(WD), .WG(WG), .WI(WI), .CH_W(CH_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_num_ch (cfg_num_ch),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .d_tile     (d_tile),
      .g_tile     (g_tile),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .M          (M),
      .busy       (busy)
`ifdef WINO_EWMM_SAT_EN
      ,
      .sat_flag   (sat_flag)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int out_cnt  = 0;

   typedef struct {
      logic [NE*WI-1:0] m;
      logic             sat;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic logic [NE*WD-1:0] mk_d(input int base, input int step);
      logic [NE*WD-1:0] t;
      for (int k = 0; k < NE; k++) t[k*WD +: WD] = WD'(base + step * k);
      return t;
   endfunction

   function automatic logic [NE*WG-1:0] mk_g(input int base, input int step);
      logic [NE*WG-1:0] t;
      for (int k = 0; k < NE; k++) t[k*WG +: WG] = WG'(base + step * k);
      return t;
   endfunction

   function automatic logic [NE*WI-1:0] mk_m(input int base, input int step);
      logic [NE*WI-1:0] t;
      for (int k = 0; k < NE; k++) t[k*WI +: WI] = WI'(base + step * k);
      return t;
   endfunction

   task automatic push_exp(input logic [NE*WI-1:0] m, input logic sat);
      exp_t e;
      e.m   = m;
      e.sat = sat;
      sb.push_back(e);
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Holds a beat until accepted; returns just after the accepting edge.
   task automatic send_beat(input logic [NE*WD-1:0] d, input logic [NE*WG-1:0] g, input int n);
      int t;
      t          = 0;
      d_tile     = d;
      g_tile     = g;
      cfg_num_ch = CH_W'(n);
      in_valid   = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout got=in_ready_low exp=in_ready_high");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_mvalid_low(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while (m_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk(name, m_valid, 0);
      sync();
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      int   bad;
      if (!rst && m_valid && m_ready) begin
         out_cnt++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output got=m_valid exp=no_pending_group");
         end else begin
            e   = sb.pop_front();
            bad = -1;
            for (int k = NE - 1; k >= 0; k--)
               if (M[k*WI +: WI] !== e.m[k*WI +: WI]) bad = k;
            checks++;
            if (bad >= 0) begin
               failures++;
               $display("FAIL tile elem=%0d got=%0d exp=%0d", bad,
                        $signed(M[bad*WI +: WI]), $signed(e.m[bad*WI +: WI]));
            end
`ifdef WINO_EWMM_SAT_EN
            chk("sat_flag", sat_flag, e.sat);
`endif
         end
      end
   end

   initial begin : stim
      logic [NE*WI-1:0] held;
      logic             ok;
      int               o;
      int               t;

      rst        = 1'b1;
      in_valid   = 1'b0;
      m_ready    = 1'b0;
      cfg_num_ch = '0;
      d_tile     = '0;
      g_tile     = '0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_M_zero", (M == '0), 1);
      chk("rst_busy", busy, 0);
      sync();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);
      sync();

      // 1: single-channel group, latency and hold under backpressure
      m_ready = 1'b0;
      push_exp(mk_m(-24, 3), 1'b0);
      send_beat(mk_d(-8, 1), mk_g(3, 0), 1);
      @(negedge clk);
      chk("t1_lat_t1", m_valid, 0);
      chk("t1_busy", busy, 1);
      @(negedge clk);
      chk("t1_lat_t2", m_valid, 1);
      held = M;
      ok   = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (!m_valid || M !== held) ok = 1'b0;
      end
      chk("t1_hold", ok, 1);
      sync();
      m_ready = 1'b1;
      wait_mvalid_low("t1_release");

      // 2: three channels, in_ready low from DRAIN until handshake
      m_ready = 1'b0;
      push_exp(mk_m(-12, 0), 1'b0);
      for (int b = 1; b <= 3; b++) send_beat(mk_d(b, 0), mk_g(-2, 0), 3);
      @(negedge clk);
      chk("t2_rdy_drain", in_ready, 0);
      ok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (in_ready) ok = 1'b0;
      end
      chk("t2_rdy_out", ok, 1);
      chk("t2_m_valid", m_valid, 1);
      sync();
      m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t2_rdy_back", in_ready, 1);
      chk("t2_m_valid_low", m_valid, 0);
      sync();

      // 3: four channels with two-cycle gaps
      o = out_cnt;
      push_exp(mk_m(-20, 10), 1'b0);
      for (int b = 0; b < 4; b++) begin
         send_beat(mk_d(-b, 1), mk_g(b + 1, 0), 4);
         if (b < 3) repeat (2) sync();
      end
      repeat (6) @(negedge clk);
      chk("t3_once", out_cnt - o, 1);
      sync();

      // 4: 200 channels of max-magnitude products
`ifdef WINO_EWMM_SAT_EN
      push_exp(mk_m(8388607, 0), 1'b1);
`else
      push_exp(mk_m(2097152, 0), 1'b0);
`endif
      o = out_cnt;
      for (int b = 0; b < 200; b++) send_beat(mk_d(-512, 0), mk_g(-512, 0), 200);
      repeat (4) @(negedge clk);
      chk("t4_once", out_cnt - o, 1);
      sync();

      // 5: reset in the middle of a group
      o = out_cnt;
      send_beat(mk_d(1, 0), mk_g(1, 0), 4);
      send_beat(mk_d(1, 0), mk_g(1, 0), 4);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_m_valid", m_valid, 0);
      chk("t5_M_zero", (M == '0), 1);
      chk("t5_in_ready", in_ready, 0);
      chk("t5_busy", busy, 0);
      sync();
      sync();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_in_ready_back", in_ready, 1);
      chk("t5_no_partial", out_cnt - o, 0);
      sync();
      push_exp(mk_m(35, 0), 1'b0);
      send_beat(mk_d(5, 0), mk_g(7, 0), 1);
      repeat (4) sync();

      // 6: zero channel count, then back-to-back two-channel groups
      o = out_cnt;
      push_exp(mk_m(-24, 0), 1'b0);
      send_beat(mk_d(4, 0), mk_g(-6, 0), 0);
      for (int j = 0; j < 3; j++) begin
         push_exp(mk_m(-8 * (3 * j + 1), 3 * j + 1), 1'b0);
         send_beat(mk_d(j + 1, 0), mk_g(-8, 1), 2);
         send_beat(mk_d(2 * j, 0), mk_g(-8, 1), 2);
      end

      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("sb_drained", sb.size(), 0);
      chk("t6_outputs", out_cnt - o, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
